// File: rtl/hack_pkg.sv
// Shared constants and decode types for the Hack data-memory subsystem.
package hack_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned RAM_ADDR_W = 13;
  localparam int unsigned RAM_DEPTH  = 8192;

  localparam logic [WORD_W-1:0] BTN_ADDR = 16'h2000;
  localparam logic [WORD_W-1:0] LED_ADDR = 16'h2001;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_BTN  = 2'd1,
    SEL_LED  = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

endpackage

// File: rtl/hack_memory_map_ram_8k16.sv
// Single-port data RAM: asynchronous read, synchronous write, contents never reset.
module ram_8k16
  import hack_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0]     din,
  output logic [WORD_W-1:0]     dout
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/hack_memory_map.sv
// Hack data-memory map: RAM window, read-only button word and LED register,
// with a combinational read mux and a two-flop button synchroniser.
module hack_memory_map
  import hack_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] in,
  input  logic              load,
  output logic [WORD_W-1:0] out,
  input  logic              btn,
  output logic              led
);

  sel_e              sel;
  logic              led_reg;
  logic              btn_meta;
  logic              btn_sync;
  logic              ram_we;
  logic [WORD_W-1:0] ram_dout;

  // Full 16-bit decode; nothing aliases into the RAM window.
  always_comb begin
    sel = SEL_NONE;
    if (32'(address) < RAM_WORDS) sel = SEL_RAM;
    else if (address == BTN_ADDR) sel = SEL_BTN;
    else if (address == LED_ADDR) sel = SEL_LED;
  end

  // Writes are suppressed while reset is held, RAM included.
  assign ram_we = load && rst_n && (sel == SEL_RAM);

  ram_8k16 #(
    .DEPTH(RAM_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (address[RAM_ADDR_W-1:0]),
    .din  (in),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg  <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      if (load && (sel == SEL_LED)) led_reg <= in[0];
    end
  end

  always_comb begin
    out = '0;
    case (sel)
      SEL_RAM: out = ram_dout;
      SEL_BTN: out = {{(WORD_W-1){1'b0}}, btn_sync};
      SEL_LED: out = {{(WORD_W-1){1'b0}}, led_reg};
      default: out = '0;
    endcase
  end

  assign led = led_reg;

endmodule

// File: tb/tb_hack_memory_map.sv
// Directed self-checking bench for hack_memory_map.
module tb_hack_memory_map;

  logic        clk;
  logic        rst_n;
  logic [15:0] address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;
  logic        btn;
  logic        led;

  int n_checks = 0;
  int n_fail   = 0;

  hack_memory_map dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .in      (in),
    .load    (load),
    .out     (out),
    .btn     (btn),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One full clock: rising edge, then settle at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    address = 16'h0000;
    in      = 16'h0000;
    load    = 1'b0;
    btn     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    rd("rst_led_out", 16'h2001, 16'h0000);
    check("rst_led_pin", {15'b0, led}, 16'h0000);
    rd("rst_btn_out", 16'h2000, 16'h0000);
    rst_n = 1'b1;

    // Button synchroniser: two edges of latency
    btn = 1'b1;
    tick();
    rd("btn_after_1", 16'h2000, 16'h0000);
    tick();
    rd("btn_after_2", 16'h2000, 16'h0001);

    // LED register: bit 0 only
    wr(16'h2001, 16'h0001);
    check("led_set_pin", {15'b0, led}, 16'h0001);
    rd("led_set_out", 16'h2001, 16'h0001);
    wr(16'h2001, 16'hFFFE);
    check("led_clr_pin", {15'b0, led}, 16'h0000);
    rd("led_clr_out", 16'h2001, 16'h0000);

    // RAM write, then load=0 must not write
    wr(16'h0000, 16'hFFFF);
    rd("ram0_write", 16'h0000, 16'hFFFF);
    address = 16'h0000;
    in      = 16'd9999;
    load    = 1'b0;
    tick();
    rd("ram0_noload", 16'h0000, 16'hFFFF);

    // Seed words used later to detect stray writes
    wr(16'd1200, 16'h1234);
    wr(16'h1000, 16'h0ABC);
    wr(16'h1FFF, 16'hBEEF);

    // Old data before the edge, new data after
    wr(16'd1000, 16'd1111);
    address = 16'd1000;
    in      = 16'd2222;
    load    = 1'b1;
    #1;
    check("raw_before_edge", out, 16'd1111);
    tick();
    load = 1'b0;
    rd("raw_after_edge", 16'd1000, 16'd2222);
    rd("ram0_kept", 16'h0000, 16'hFFFF);
    rd("ram1200_kept", 16'd1200, 16'h1234);
    rd("ram_top_word", 16'h1FFF, 16'hBEEF);

    // Writes to the button and unmapped addresses have no side effects
    wr(16'h2001, 16'h0001);
    wr(16'h2000, 16'd12345);
    rd("btn_write_ign", 16'h2000, 16'h0001);
    check("btn_write_led", {15'b0, led}, 16'h0001);
    rd("btn_write_ram0", 16'h0000, 16'hFFFF);
    wr(16'h3000, 16'h5555);
    rd("unmapped_3000", 16'h3000, 16'h0000);
    rd("alias_ram1000", 16'h1000, 16'h0ABC);
    rd("unmapped_2002", 16'h2002, 16'h0000);
    rd("unmapped_ffff", 16'hFFFF, 16'h0000);
    check("unmapped_led", {15'b0, led}, 16'h0001);

    // Asynchronous reset mid-cycle; writes blocked while held
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", {15'b0, led}, 16'h0000);
    address = 16'd1000;
    in      = 16'd7777;
    load    = 1'b1;
    #1;
    check("rst_ram_read", out, 16'd2222);
    tick();
    rd("rst_ram_blocked", 16'd1000, 16'd2222);
    address = 16'h2001;
    in      = 16'h0001;
    tick();
    check("rst_led_blocked", {15'b0, led}, 16'h0000);
    rd("rst_btn_cleared", 16'h2000, 16'h0000);
    load  = 1'b0;
    rst_n = 1'b1;
    rd("post_rst_ram", 16'd1000, 16'd2222);
    rd("post_rst_led", 16'h2001, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
